// File: rtl/wor_arb_pkg.sv
// Shared types and defaults for the wired-OR arbitration node.
// The parity state exists only when WOR_ARB_PARITY_EN is defined.
package wor_arb_pkg;

    localparam int unsigned DEF_ID_W      = 4;
    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_BIT_TICKS = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARB  = 3'd1,
        ST_DATA = 3'd2,
`ifdef WOR_ARB_PARITY_EN
        ST_PAR  = 3'd3,
`endif
        ST_DONE = 3'd4
    } state_e;

    // Counter width for values 0..n-1, never below one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wor_arb_node_timer.sv
// Bit-period timer: counts ticks within one bus bit.
// last_tick_o marks the final cycle of the current bit.
module wor_bit_timer
    import wor_arb_pkg::*;
#(
    parameter int unsigned BIT_TICKS = DEF_BIT_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic last_tick_o
);

    localparam int unsigned   TW   = cnt_w(BIT_TICKS);
    localparam logic [TW-1:0] LAST = TW'(BIT_TICKS - 1);

    logic [TW-1:0] tick_q;
    logic [TW-1:0] tick_d;

    assign last_tick_o = (tick_q == LAST);

    always_comb begin
        tick_d = tick_q;
        if (clr_i) begin
            tick_d = '0;
        end else if (en_i) begin
            tick_d = last_tick_o ? '0 : tick_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/wor_arb_node.sv
// Wired-OR bus arbitration node: ID arbitration, payload, optional
// even parity bit (WOR_ARB_PARITY_EN). Logic 1 dominates the bus.
module wor_arb_node
    import wor_arb_pkg::*;
#(
    parameter int unsigned ID_W      = DEF_ID_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned BIT_TICKS = DEF_BIT_TICKS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [ID_W-1:0]   id,
    input  logic [DATA_W-1:0] data,
    input  logic              bus_in,
    output logic              bus_drv,
    output logic              busy,
    output logic              done,
    output logic              won
);

    localparam int unsigned   MAXW      = (ID_W > DATA_W) ? ID_W : DATA_W;
    localparam int unsigned   CW        = cnt_w(MAXW);
    localparam logic [CW-1:0] ID_LAST   = CW'(ID_W - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CW-1:0]     bit_q, bit_d;
    logic              won_q, won_d;
`ifdef WOR_ARB_PARITY_EN
    logic              par_q, par_d;
`endif

    logic accept;
    logic timing;
    logic last_tick;
    logic lost;

    assign accept = (state_q == ST_IDLE) && req;

    // A recessive bit that reads back dominant means another node won.
    assign lost = (state_q == ST_ARB) && last_tick
               && !id_q[ID_W-1] && bus_in;

    always_comb begin
        timing = 1'b0;
        unique case (state_q)
            ST_ARB:  timing = 1'b1;
            ST_DATA: timing = 1'b1;
`ifdef WOR_ARB_PARITY_EN
            ST_PAR:  timing = 1'b1;
`endif
            default: timing = 1'b0;
        endcase
    end

    wor_bit_timer #(
        .BIT_TICKS(BIT_TICKS)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (accept),
        .en_i       (timing),
        .last_tick_o(last_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (lost) begin
                    state_d = ST_DONE;
                end else if (last_tick && bit_q == ID_LAST) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (last_tick && bit_q == DATA_LAST) begin
`ifdef WOR_ARB_PARITY_EN
                    state_d = ST_PAR;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef WOR_ARB_PARITY_EN
            ST_PAR: begin
                if (last_tick) state_d = ST_DONE;
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // id/data are kept as shift registers; the MSB is the bit on the bus.
    always_comb begin
        id_d   = id_q;
        data_d = data_q;
        bit_d  = bit_q;
        won_d  = won_q;
`ifdef WOR_ARB_PARITY_EN
        par_d  = par_q;
`endif
        if (accept) begin
            id_d   = id;
            data_d = data;
            bit_d  = '0;
            won_d  = 1'b0;
`ifdef WOR_ARB_PARITY_EN
            par_d  = ^data;
`endif
        end else if (last_tick && state_q == ST_ARB) begin
            id_d  = id_q << 1;
            bit_d = (bit_q == ID_LAST) ? '0 : bit_q + CW'(1);
        end else if (last_tick && state_q == ST_DATA) begin
            data_d = data_q << 1;
            bit_d  = (bit_q == DATA_LAST) ? '0 : bit_q + CW'(1);
        end
        if (state_d == ST_DONE && state_q != ST_DONE && !lost) begin
            won_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q   <= '0;
            data_q <= '0;
            bit_q  <= '0;
            won_q  <= 1'b0;
`ifdef WOR_ARB_PARITY_EN
            par_q  <= 1'b0;
`endif
        end else begin
            id_q   <= id_d;
            data_q <= data_d;
            bit_q  <= bit_d;
            won_q  <= won_d;
`ifdef WOR_ARB_PARITY_EN
            par_q  <= par_d;
`endif
        end
    end

    always_comb begin
        bus_drv = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: busy    = 1'b0;
            ST_ARB:  bus_drv = id_q[ID_W-1];
            ST_DATA: bus_drv = data_q[DATA_W-1];
`ifdef WOR_ARB_PARITY_EN
            ST_PAR:  bus_drv = par_q;
`endif
            ST_DONE: done    = 1'b1;
            default: busy    = 1'b0;
        endcase
    end

    assign won = won_q;

endmodule

// File: tb/tb_wor_arb_node.sv
// Directed bench for wor_arb_node: two nodes on a shared wired-OR bus
// plus a slow (BIT_TICKS=3) node on its own loopback bus.
module tb_wor_arb_node;

`ifdef WOR_ARB_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int WIN  = 13 + P;
    localparam int WINC = 37 + 3 * P;

    typedef struct {
        logic       ra;
        logic [3:0] ida;
        logic [7:0] da;
        logic       rb;
        logic [3:0] idb;
        logic [7:0] db;
        int         dca;
        logic       wa;
        int         dcb;
        logic       wb;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a, req_b, req_c;
    logic [3:0] id_a, id_b, id_c;
    logic [7:0] data_a, data_b, data_c;
    logic       drv_a, drv_b, drv_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;
    logic       won_a, won_b, won_c;
    logic       bus_ab;

    int checks = 0;
    int errors = 0;
    vec_t vecs[9];

    assign bus_ab = drv_a | drv_b;

    always #5 clk = ~clk;

    wor_arb_node u_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .id(id_a),
        .data(data_a), .bus_in(bus_ab), .bus_drv(drv_a),
        .busy(busy_a), .done(done_a), .won(won_a)
    );

    wor_arb_node u_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .id(id_b),
        .data(data_b), .bus_in(bus_ab), .bus_drv(drv_b),
        .busy(busy_b), .done(done_b), .won(won_b)
    );

    wor_arb_node #(.BIT_TICKS(3)) u_c (
        .clk(clk), .rst_n(rst_n), .req(req_c), .id(id_c),
        .data(data_c), .bus_in(drv_c), .bus_drv(drv_c),
        .busy(busy_c), .done(done_c), .won(won_c)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Serial stream {id, data, parity}; nothing is driven from done on.
    function automatic logic exp_bit(input logic [3:0] i,
                                     input logic [7:0] d,
                                     input int k);
        logic [12:0] s;
        s = {i, d, ^d};
        return s[12 - k];
    endfunction

    // Called at a negedge (cycle 0); returns at a negedge.
    task automatic run_vec(input int n, input vec_t v);
        int fa, fb, pa, pb, bad_da, bad_db, bad_ba, bad_bb;
        logic wda, wdb, ea, eb;
        fa = 0; fb = 0; pa = 0; pb = 0;
        bad_da = 0; bad_db = 0; bad_ba = 0; bad_bb = 0;
        wda = 1'bx; wdb = 1'bx;
        req_a = v.ra; id_a = v.ida; data_a = v.da;
        req_b = v.rb; id_b = v.idb; data_b = v.db;
        @(negedge clk);
        req_a = 1'b0; req_b = 1'b0;
        id_a = ~v.ida; data_a = ~v.da;
        id_b = ~v.idb; data_b = ~v.db;
        for (int c = 1; c <= 20; c++) begin
            if (done_a) begin
                pa++;
                if (fa == 0) fa = c;
                wda = won_a;
            end
            if (done_b) begin
                pb++;
                if (fb == 0) fb = c;
                wdb = won_b;
            end
            ea = (v.ra && c < v.dca) ? exp_bit(v.ida, v.da, c - 1) : 1'b0;
            eb = (v.rb && c < v.dcb) ? exp_bit(v.idb, v.db, c - 1) : 1'b0;
            if (drv_a !== ea) bad_da++;
            if (drv_b !== eb) bad_db++;
            if (busy_a !== (v.ra && c <= v.dca)) bad_ba++;
            if (busy_b !== (v.rb && c <= v.dcb)) bad_bb++;
            @(negedge clk);
        end
        chk($sformatf("v%0d_a_done_cycle", n), fa, v.ra ? v.dca : 0);
        chk($sformatf("v%0d_a_pulses", n), pa, v.ra ? 1 : 0);
        chk($sformatf("v%0d_a_drv_errs", n), bad_da, 0);
        chk($sformatf("v%0d_a_busy_errs", n), bad_ba, 0);
        chk($sformatf("v%0d_b_done_cycle", n), fb, v.rb ? v.dcb : 0);
        chk($sformatf("v%0d_b_pulses", n), pb, v.rb ? 1 : 0);
        chk($sformatf("v%0d_b_drv_errs", n), bad_db, 0);
        chk($sformatf("v%0d_b_busy_errs", n), bad_bb, 0);
        if (v.ra) begin
            chk($sformatf("v%0d_a_won_at_done", n), wda, v.wa);
            chk($sformatf("v%0d_a_won_held", n), won_a, v.wa);
        end
        if (v.rb) begin
            chk($sformatf("v%0d_b_won_at_done", n), wdb, v.wb);
            chk($sformatf("v%0d_b_won_held", n), won_b, v.wb);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'b1010, 8'hA5, 1'b0, 4'b0000, 8'h00,
                    WIN, 1'b1, 0, 1'b0};
        vecs[1] = '{1'b1, 4'b1010, 8'hA5, 1'b1, 4'b1001, 8'h3C,
                    WIN, 1'b1, 4, 1'b0};
        vecs[2] = '{1'b1, 4'b1001, 8'h11, 1'b1, 4'b1010, 8'hF0,
                    4, 1'b0, WIN, 1'b1};
        vecs[3] = '{1'b1, 4'b0110, 8'h3C, 1'b1, 4'b0110, 8'hC3,
                    WIN, 1'b1, WIN, 1'b1};
        vecs[4] = '{1'b1, 4'b0000, 8'hFF, 1'b1, 4'b0001, 8'h00,
                    5, 1'b0, WIN, 1'b1};
        vecs[5] = '{1'b1, 4'b1000, 8'h5A, 1'b1, 4'b0111, 8'hFF,
                    WIN, 1'b1, 2, 1'b0};
        vecs[6] = '{1'b1, 4'b0000, 8'h00, 1'b0, 4'b0000, 8'h00,
                    WIN, 1'b1, 0, 1'b0};
        vecs[7] = '{1'b1, 4'b1010, 8'h07, 1'b0, 4'b0000, 8'h00,
                    WIN, 1'b1, 0, 1'b0};
        vecs[8] = '{1'b0, 4'b0000, 8'h00, 1'b1, 4'b1111, 8'h81,
                    0, 1'b0, WIN, 1'b1};

        rst_n = 1'b0;
        req_a = 1'b0; id_a = '0; data_a = '0;
        req_b = 1'b0; id_b = '0; data_b = '0;
        req_c = 1'b0; id_c = '0; data_c = '0;
        #2;
        chk("rst_drv", {drv_a, drv_b, drv_c}, 3'b000);
        chk("rst_busy", {busy_a, busy_b, busy_c}, 3'b000);
        chk("rst_done", {done_a, done_b, done_c}, 3'b000);
        chk("rst_won", {won_a, won_b, won_c}, 3'b000);

        // Release and request on the same negedge: first edge accepts.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Reset in the middle of the data phase.
        req_a = 1'b1; id_a = 4'b1010; data_a = 8'hA5;
        @(negedge clk);
        req_a = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_busy_before_rst", busy_a, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_drv", drv_a, 1'b0);
        chk("mid_rst_busy", busy_a, 1'b0);
        chk("mid_rst_done", done_a, 1'b0);
        chk("mid_rst_won", won_a, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(100, vecs[0]);

        // req pulsed while busy and held during DONE is ignored.
        begin
            int pulses, first;
            logic busy_after;
            pulses = 0; first = 0; busy_after = 1'bx;
            req_a = 1'b1; id_a = 4'b1010; data_a = 8'hA5;
            @(negedge clk);
            req_a = 1'b0;
            for (int c = 1; c <= 30; c++) begin
                if (done_a) begin
                    pulses++;
                    if (first == 0) first = c;
                end
                if (c == WIN + 1) busy_after = busy_a;
                req_a = (c == 5) || (c == WIN);
                @(negedge clk);
            end
            req_a = 1'b0;
            chk("busy_req_pulses", pulses, 1);
            chk("busy_req_done_cycle", first, WIN);
            chk("busy_req_idle_after", busy_after, 1'b0);
        end

        // Slow node: three cycles per bit.
        begin
            int pulses, first, bad;
            logic wd, e;
            pulses = 0; first = 0; bad = 0; wd = 1'bx;
            req_c = 1'b1; id_c = 4'b0001; data_c = 8'hA5;
            @(negedge clk);
            req_c = 1'b0;
            for (int c = 1; c <= 45; c++) begin
                if (done_c) begin
                    pulses++;
                    if (first == 0) first = c;
                    wd = won_c;
                end
                e = (c < WINC) ? exp_bit(4'b0001, 8'hA5, (c - 1) / 3)
                               : 1'b0;
                if (drv_c !== e) bad++;
                @(negedge clk);
            end
            chk("slow_done_cycle", first, WINC);
            chk("slow_pulses", pulses, 1);
            chk("slow_drv_errs", bad, 0);
            chk("slow_won", wd, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
